// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
package mux_arb_pkg;

    typedef enum logic [0:0] {IDLE, GRANT} state_t;

    localparam int unsigned DEF_N           = 8;
    localparam int unsigned DEF_SLOT_CYCLES = 4;
    localparam int unsigned MAX_N           = 32;

    // Callers size-cast the result down to their own requester count.
    function automatic logic [MAX_N-1:0] onehot(input int unsigned idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit at or after ptr, wrapping mod N.
module rr_pick #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);

    localparam int unsigned W = $clog2(N);

    always_comb begin
        logic [W-1:0] cand;
        cand  = '0;
        found = |req;
        idx   = ptr;
        // Walk offsets from farthest to nearest so the nearest set bit wins;
        // N is a power of two, so W-bit addition wraps for free.
        for (int i = N - 1; i >= 0; i--) begin
            cand = ptr + W'(i);
            if (req[cand]) idx = cand;
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared N-to-1 mux, with per-grant slot timeout
// and a mandatory idle cycle between grants.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned N           = DEF_N,
    parameter int unsigned SLOT_CYCLES = DEF_SLOT_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N-1:0]         req,
    output logic [$clog2(N)-1:0] sel,
    output logic [N-1:0]         grant,
    output logic                 valid
);

    localparam int unsigned W  = $clog2(N);
    localparam int unsigned CW = $clog2(SLOT_CYCLES) + 1;

    state_t         state_q, state_d;
    logic [W-1:0]   sel_q, sel_d;
    logic [N-1:0]   grant_q, grant_d;
    logic           valid_q, valid_d;
    logic [W-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           pick_found;
    logic [W-1:0]   pick_idx;

    rr_pick #(
        .N (N)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        grant_d = '0;
        valid_d = 1'b0;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    sel_d   = pick_idx;
                    grant_d = N'(onehot(32'(pick_idx)));
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                // Drop and timeout on the same cycle collapse into one release.
                if (!req[sel_q] || cnt_q == CW'(SLOT_CYCLES - 1)) begin
                    state_d = IDLE;
                    ptr_d   = sel_q + W'(1);
                end else begin
                    grant_d = grant_q;
                    valid_d = 1'b1;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sel   = sel_q;
    assign grant = grant_q;
    assign valid = valid_q;

endmodule
